// File: rtl/ram_port_arbiter_if.sv
// Bundle between the requester fabric, the arbiter and one async RAM port.
// Ports: req/req_we/req_addr/req_wdata and ram_rdata are driven by the master side;
//        gnt/rdata/rvalid/busy and the ram_* pin signals are driven by the arbiter (slave).
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          rvalid;
  logic                          busy;
  logic [ADDR_WIDTH-1:0]         ram_address;
  logic                          ram_cs;
  logic                          ram_we;
  logic                          ram_oe;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic                          ram_drive;
  logic [DATA_WIDTH-1:0]         ram_rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, ram_rdata,
    input  gnt, rdata, rvalid, busy,
    input  ram_address, ram_cs, ram_we, ram_oe, ram_wdata, ram_drive
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_rdata,
    output gnt, rdata, rvalid, busy,
    output ram_address, ram_cs, ram_we, ram_oe, ram_wdata, ram_drive
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one async RAM port among NUM_REQ requesters;
// each transaction walks IDLE -> SETUP -> ACCESS -> RELEASE, gnt pulses 3 cycles after arbitration.
// Ports: clk, reset_n (async, active low), bus (slave modport: requests in, grants/read data/RAM pins out).
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int PTR_W      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      win_q, win_d;
  logic                  we_q, we_d;
  logic [PTR_W-1:0]      arb_idx;

  // Registered outputs
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cs_q, cs_d;
  logic                  rwe_q, rwe_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  drive_q, drive_d;

  // Round-robin search: walking k downwards leaves the candidate closest to ptr as the winner.
  always_comb begin
    logic [PTR_W-1:0] cand;
    arb_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req[cand]) arb_idx = cand;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    we_d     = we_q;
    gnt_d    = '0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    rwe_d    = rwe_q;
    oe_d     = oe_q;
    wdata_d  = wdata_q;
    drive_d  = drive_q;

    case (state_q)
      IDLE: begin
        addr_d  = '0;
        cs_d    = 1'b0;
        rwe_d   = 1'b0;
        oe_d    = 1'b0;
        wdata_d = '0;
        drive_d = 1'b0;
        if (|bus.req) begin
          state_d = SETUP;
          win_d   = arb_idx;
          cs_d    = 1'b1;
          // Constant-index selection keeps the request fields free of variable part-selects.
          for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == arb_idx) begin
              we_d    = bus.req_we[i];
              rwe_d   = bus.req_we[i];
              drive_d = bus.req_we[i];
              oe_d    = ~bus.req_we[i];
              addr_d  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;  // strobes and bus hold for a second cycle
      end
      ACCESS: begin
        state_d  = RELEASE;
        cs_d     = 1'b0;
        rwe_d    = 1'b0;
        oe_d     = 1'b0;
        drive_d  = 1'b0;
        rvalid_d = ~we_q;
        if (!we_q) rdata_d = bus.ram_rdata;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (PTR_W'(i) == win_q) gnt_d[i] = 1'b1;
        end
        ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      RELEASE: begin
        // Address/data were held through RELEASE for hold time; park them now.
        state_d = IDLE;
        addr_d  = '0;
        wdata_d = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      rwe_q    <= 1'b0;
      oe_q     <= 1'b0;
      wdata_q  <= '0;
      drive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      rwe_q    <= rwe_d;
      oe_q     <= oe_d;
      wdata_q  <= wdata_d;
      drive_q  <= drive_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rdata       = rdata_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.busy        = busy_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_cs      = cs_q;
  assign bus.ram_we      = rwe_q;
  assign bus.ram_oe      = oe_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.ram_drive   = drive_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed transaction table, multi-cycle sequences, random traffic.
// Ports: none; instantiates the interface, the arbiter and a small behavioural RAM.
module tb_ram_port_arbiter;

  logic clk;
  logic reset_n;
  int   tests;
  int   failed;
  logic [7:0] mem [256];
  logic last_read;

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural async RAM on the port
  assign bus.ram_rdata = (bus.ram_cs && bus.ram_oe) ? mem[bus.ram_address] : 8'h00;
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) mem[bus.ram_address] <= bus.ram_wdata;
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  ram_addr;
    logic        is_wr;
    logic [7:0]  wr_data;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string name, input logic [3:0] exp);
    logic [3:0] g;
    logic       seen;
    g    = '0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!seen) begin
        tick();
        if (bus.gnt != 4'b0) begin
          g    = bus.gnt;
          seen = 1'b1;
        end
      end
    end
    chk(name, {28'b0, g}, {28'b0, exp});
  endtask

  // Issues one transaction from IDLE and checks it cycle by cycle, ending back in IDLE.
  task automatic run_txn(input vec_t v, input int n);
    bus.req       = v.req;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    tick();  // arbitration edge -> SETUP
    chk($sformatf("v%0d setup cs", n), {31'b0, bus.ram_cs}, 32'd1);
    chk($sformatf("v%0d setup addr", n), {24'b0, bus.ram_address}, {24'b0, v.ram_addr});
    chk($sformatf("v%0d setup we", n), {31'b0, bus.ram_we}, {31'b0, v.is_wr});
    chk($sformatf("v%0d setup oe", n), {31'b0, bus.ram_oe}, {31'b0, ~v.is_wr});
    chk($sformatf("v%0d setup drive", n), {31'b0, bus.ram_drive}, {31'b0, v.is_wr});
    chk($sformatf("v%0d busy", n), {31'b0, bus.busy}, 32'd1);
    if (v.is_wr) chk($sformatf("v%0d wdata", n), {24'b0, bus.ram_wdata}, {24'b0, v.wr_data});
    // Inputs change after arbitration; the latched transaction must not notice.
    bus.req       = 4'b0;
    bus.req_addr  = ~v.addr;
    bus.req_wdata = ~v.wdata;
    bus.req_we    = ~v.we;
    tick();  // ACCESS
    chk($sformatf("v%0d access cs", n), {31'b0, bus.ram_cs}, 32'd1);
    chk($sformatf("v%0d access addr", n), {24'b0, bus.ram_address}, {24'b0, v.ram_addr});
    chk($sformatf("v%0d access we", n), {31'b0, bus.ram_we}, {31'b0, v.is_wr});
    chk($sformatf("v%0d gnt early", n), {28'b0, bus.gnt}, 32'd0);
    tick();  // RELEASE
    chk($sformatf("v%0d gnt", n), {28'b0, bus.gnt}, {28'b0, v.gnt});
    chk($sformatf("v%0d rvalid", n), {31'b0, bus.rvalid}, {31'b0, ~v.is_wr});
    chk($sformatf("v%0d rdata", n), {24'b0, bus.rdata}, {24'b0, v.rdata});
    chk($sformatf("v%0d release cs", n), {31'b0, bus.ram_cs}, 32'd0);
    chk($sformatf("v%0d release hold addr", n), {24'b0, bus.ram_address}, {24'b0, v.ram_addr});
    tick();  // IDLE
    chk($sformatf("v%0d idle gnt", n), {28'b0, bus.gnt}, 32'd0);
    chk($sformatf("v%0d idle busy", n), {31'b0, bus.busy}, 32'd0);
    chk($sformatf("v%0d idle addr", n), {24'b0, bus.ram_address}, 32'd0);
  endtask

  // Pin-level invariants on every cycle
  always @(negedge clk) begin
    if (bus.ram_cs) last_read = ~bus.ram_we;
    chk("inv drive_oe", {31'b0, bus.ram_drive && bus.ram_oe}, 32'd0);
    chk("inv gnt onehot0", {31'b0, $onehot0(bus.gnt)}, 32'd1);
    chk("inv strobe needs cs", {31'b0, (bus.ram_we || bus.ram_oe) && !bus.ram_cs}, 32'd0);
    chk("inv rvalid after read", {31'b0, bus.rvalid && !last_read}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    failed    = 0;
    last_read = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;

    vecs[0] = '{4'b0001, 4'b0001, 32'h33221112, 32'h443322A5, 4'b0001, 8'h12, 1'b1, 8'hA5, 8'h00};
    vecs[1] = '{4'b0001, 4'b0000, 32'h33221112, 32'h00000000, 4'b0001, 8'h12, 1'b0, 8'h00, 8'hA5};
    vecs[2] = '{4'b0010, 4'b0010, 32'h0000FF00, 32'h11110011, 4'b0010, 8'hFF, 1'b1, 8'h00, 8'hA5};
    vecs[3] = '{4'b1001, 4'b0000, 32'hFF000012, 32'h00000000, 4'b1000, 8'hFF, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{4'b1001, 4'b1001, 32'h120000FF, 32'h000000FF, 4'b0001, 8'hFF, 1'b1, 8'hFF, 8'h00};
    vecs[5] = '{4'b0110, 4'b0100, 32'h0040FF00, 32'h00770000, 4'b0010, 8'hFF, 1'b0, 8'h00, 8'hFF};
    vecs[6] = '{4'b0011, 4'b0011, 32'h00004140, 32'h00005A3C, 4'b0001, 8'h40, 1'b1, 8'h3C, 8'hFF};
    vecs[7] = '{4'b1100, 4'b1000, 32'h12400000, 32'h99000000, 4'b0100, 8'h40, 1'b0, 8'h00, 8'h3C};
    vecs[8] = '{4'b1111, 4'b0000, 32'h124041FF, 32'h00000000, 4'b1000, 8'h12, 1'b0, 8'h00, 8'hA5};
    vecs[9] = '{4'b0110, 4'b0000, 32'h00FF4000, 32'h00000000, 4'b0010, 8'h40, 1'b0, 8'h00, 8'h3C};

    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    tick();
    tick();
    chk("reset gnt", {28'b0, bus.gnt}, 32'd0);
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset rdata", {24'b0, bus.rdata}, 32'd0);
    chk("reset cs/we/oe/drive", {28'b0, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_drive}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle no req busy", {31'b0, bus.busy}, 32'd0);

    for (int n = 0; n < 10; n++) run_txn(vecs[n], n);

    // Continuous requests from everyone: 4-cycle rotation, busy low only in IDLE.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    bus.req    = 4'b1111;
    bus.req_we = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] eg;
      tick();
      case (k)
        3, 19:   eg = 4'b0001;
        7:       eg = 4'b0010;
        11:      eg = 4'b0100;
        15:      eg = 4'b1000;
        default: eg = 4'b0000;
      endcase
      chk($sformatf("rr gnt k%0d", k), {28'b0, bus.gnt}, {28'b0, eg});
      chk($sformatf("rr busy k%0d", k), {31'b0, bus.busy}, {31'b0, (k % 4) != 0});
    end
    bus.req = 4'b0000;

    // ptr=2 after a grant to requester 1, then 1001 -> requester 3 before 0.
    bus.req = 4'b0010;
    wait_gnt("ptr2 setup gnt", 4'b0010);
    bus.req = 4'b1001;
    wait_gnt("ptr2 first", 4'b1000);
    wait_gnt("ptr2 second", 4'b0001);
    bus.req = 4'b0000;
    tick();

    // Reset during ACCESS of a write aborts it; ptr returns to 0.
    bus.req       = 4'b0001;
    bus.req_we    = 4'b0001;
    bus.req_addr  = 32'h00000020;
    bus.req_wdata = 32'h00000077;
    tick();
    bus.req = 4'b0000;
    tick();
    chk("abort access cs/we/drive", {29'b0, bus.ram_cs, bus.ram_we, bus.ram_drive}, 32'd7);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort async cs/we/drive", {29'b0, bus.ram_cs, bus.ram_we, bus.ram_drive}, 32'd0);
    chk("abort async busy", {31'b0, bus.busy}, 32'd0);
    tick();
    chk("abort no gnt", {28'b0, bus.gnt}, 32'd0);
    tick();
    chk("abort no gnt 2", {28'b0, bus.gnt}, 32'd0);
    reset_n    = 1'b1;
    bus.req    = 4'b1111;
    bus.req_we = 4'b0000;
    wait_gnt("after reset winner", 4'b0001);
    bus.req = 4'b0000;
    tick();

    // Random traffic; the invariant monitor does the checking.
    for (int k = 0; k < 400; k++) begin
      bus.req       = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      bus.req_we    = 4'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      tick();
    end
    bus.req = 4'b0000;
    repeat (6) tick();
    chk("random end idle", {31'b0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
